// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the unified instruction/data memory port.
// Imported by the arbiter and by the multi-cycle latency counter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_IF,
    ARB_GRANT_D
  } arb_state_t;

  localparam int unsigned DEF_MEM_LAT    = 2;
  localparam int unsigned DEF_STARVE_MAX = 4;

  function automatic int unsigned cnt_w(int unsigned max_v);
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF port, data port and memory-side signals of the arbiter.
// slave = arbiter side, master = pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;
  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_ready, if_rdata,
    output d_ready, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem, busy
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_ready, if_rdata,
    input  d_ready, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem, busy
  );

endinterface

// File: rtl/mem_lat_counter.sv
// Fixed-latency access counter: load restarts at 0, counts up to LAT
// and holds; tc_o flags the last wait cycle of a running access.
module mem_lat_counter
  import cpu_mem_pkg::*;
#(
  parameter  int unsigned LAT = DEF_MEM_LAT,
  localparam int unsigned W   = cnt_w(LAT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         run_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] TOP  = W'(LAT);
  localparam logic [W-1:0] LAST = W'(LAT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = '0;
    else if (run_i && cnt_q != TOP)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = run_i && !load_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes IF fetches and MEM-stage loads/stores onto one memory port,
// data first, with a starvation cap that forces an IF grant.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input logic               clk,
  input logic               start,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CW = cnt_w(MEM_LAT);
  localparam int unsigned SW = cnt_w(STARVE_MAX);
  localparam logic [CW-1:0] C_TOP = CW'(MEM_LAT);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

  arb_state_t        state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_rdy_q, if_rdy_d;
  logic              d_rdy_q, d_rdy_d;

  logic          idle, starve, pick_d, pick_if;
  logic          load, run, tc, done;
  logic [CW-1:0] cnt;

  assign idle    = (state_q == ARB_IDLE);
  assign starve  = bus.if_req && (streak_q == S_MAX);
  assign pick_d  = bus.d_req && !starve;
  assign pick_if = bus.if_req && !pick_d;
  assign load    = idle && (pick_d || pick_if);
  assign run     = !idle;
  // The ready cycle is the last GRANT cycle, so a held req is not resampled.
  assign done    = run && (cnt == C_TOP);

  mem_lat_counter #(
    .LAT(MEM_LAT)
  ) u_lat (
    .clk   (clk),
    .rst_n (start),
    .load_i(load),
    .run_i (run),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

  always_ff @(posedge clk or negedge start) begin
    if (!start) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_d)       state_d = ARB_GRANT_D;
        else if (pick_if) state_d = ARB_GRANT_IF;
      end
      ARB_GRANT_IF,
      ARB_GRANT_D: begin
        if (done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en = run && (cnt == '0);
    bus.mem_we = bus.mem_en && we_q;
    bus.busy   = run;
  end

  always_comb begin
    streak_d   = streak_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_rdy_d   = 1'b0;
    d_rdy_d    = 1'b0;
    if (idle && pick_d) begin
      addr_d  = bus.d_addr;
      wdata_d = bus.d_wdata;
      we_d    = bus.d_we;
      if (!bus.if_req)          streak_d = '0;
      else if (streak_q != S_MAX) streak_d = streak_q + SW'(1);
    end else if (idle && pick_if) begin
      addr_d   = bus.if_addr;
      we_d     = 1'b0;
      streak_d = '0;
    end
    if (tc && state_q == ARB_GRANT_IF) begin
      if_rdata_d = bus.mem_rdata;
      if_rdy_d   = 1'b1;
    end else if (tc && state_q == ARB_GRANT_D) begin
      if (!we_q) d_rdata_d = bus.mem_rdata;
      d_rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      streak_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_rdy_q   <= 1'b0;
      d_rdy_q    <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_rdy_q   <= if_rdy_d;
      d_rdy_q    <= d_rdy_d;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ready  = if_rdy_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_rdy_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall_if  = bus.if_req && !if_rdy_q;
  assign bus.stall_mem = bus.d_req && !d_rdy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, collision,
// store, starvation cap and mid-access reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic start;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk  (clk),
    .start(start),
    .bus  (bus)
  );

  function automatic logic [31:0] mem_model(logic [31:0] a);
    case (a)
      32'h10:  return 32'h0050_0093;
      32'h40:  return 32'h0000_DEAD;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign bus.mem_rdata = mem_model(bus.mem_addr);

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int g;
    start       = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // reset hold with a pending fetch
    repeat (3) begin
      cyc();
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_busy", bus.busy, 0);
    end
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_if_ready", bus.if_ready, 0);
    chk("rst_d_ready", bus.d_ready, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    start = 1'b1;

    // single fetch
    cyc();
    chk("f_mem_en1", bus.mem_en, 1);
    chk("f_mem_addr", bus.mem_addr, 32'h10);
    chk("f_mem_we", bus.mem_we, 0);
    chk("f_stall_if", bus.stall_if, 1);
    chk("f_busy", bus.busy, 1);
    cyc();
    chk("f_mem_en2", bus.mem_en, 0);
    chk("f_rdy_early", bus.if_ready, 0);
    cyc();
    chk("f_if_ready", bus.if_ready, 1);
    chk("f_if_rdata", bus.if_rdata, 32'h0050_0093);
    chk("f_stall_rel", bus.stall_if, 0);
    bus.if_req = 1'b0;
    cyc();
    chk("f_rdy_pulse", bus.if_ready, 0);
    chk("f_idle", bus.busy, 0);
    cyc();
    chk("f_rdata_hold", bus.if_rdata, 32'h0050_0093);

    // collision: data first, then IF
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h40;
    cyc();
    chk("c_mem_en", bus.mem_en, 1);
    chk("c_mem_addr", bus.mem_addr, 32'h40);
    chk("c_stall_if1", bus.stall_if, 1);
    chk("c_stall_mem", bus.stall_mem, 1);
    cyc();
    chk("c_stall_if2", bus.stall_if, 1);
    cyc();
    chk("c_d_ready", bus.d_ready, 1);
    chk("c_d_rdata", bus.d_rdata, 32'h0000_DEAD);
    chk("c_stall_if3", bus.stall_if, 1);
    chk("c_if_ready", bus.if_ready, 0);
    bus.d_req = 1'b0;
    cyc();
    chk("c_gap_idle", bus.busy, 0);
    chk("c_stall_if4", bus.stall_if, 1);
    cyc();
    chk("c_if_en", bus.mem_en, 1);
    chk("c_if_addr", bus.mem_addr, 32'h20);
    cyc(2);
    chk("c_if_ready2", bus.if_ready, 1);
    chk("c_if_rdata", bus.if_rdata, 32'hA5A5_0020);
    bus.if_req = 1'b0;
    cyc();
    chk("c_d_hold", bus.d_rdata, 32'h0000_DEAD);

    // store leaves d_rdata alone
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h80;
    bus.d_wdata = 32'h1234;
    cyc();
    chk("s_mem_en", bus.mem_en, 1);
    chk("s_mem_we", bus.mem_we, 1);
    chk("s_mem_addr", bus.mem_addr, 32'h80);
    chk("s_mem_wdata", bus.mem_wdata, 32'h1234);
    cyc();
    chk("s_we_drop", bus.mem_we, 0);
    cyc();
    chk("s_d_ready", bus.d_ready, 1);
    chk("s_d_rdata", bus.d_rdata, 32'h0000_DEAD);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    cyc();
    chk("s_idle", bus.busy, 0);

    // starvation cap: 4 data grants, then 1 IF grant
    bus.d_addr  = 32'h44;
    bus.d_req   = 1'b1;
    bus.if_addr = 32'h30;
    bus.if_req  = 1'b1;
    g = 0;
    for (int c = 0; c < 80 && g < 10; c++) begin
      cyc();
      if (bus.mem_en) begin
        chk($sformatf("starve_g%0d", g), bus.mem_addr,
            (g % 5 == 4) ? 32'h30 : 32'h44);
        g++;
      end
    end
    chk("starve_count", g, 10);
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    for (int c = 0; c < 10 && bus.busy; c++) cyc();
    chk("drain_idle", bus.busy, 0);
    cyc();

    // reset in the first GRANT_D cycle
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h48;
    cyc();
    chk("m_busy", bus.busy, 1);
    chk("m_mem_en", bus.mem_en, 1);
    #1;
    start     = 1'b0;
    bus.d_req = 1'b0;
    #1;
    chk("m_busy_rst", bus.busy, 0);
    chk("m_en_rst", bus.mem_en, 0);
    chk("m_addr_rst", bus.mem_addr, 0);
    chk("m_drdata_rst", bus.d_rdata, 0);
    cyc(2);
    start = 1'b1;
    repeat (4) begin
      cyc();
      chk("m_no_ready", bus.d_ready, 0);
      chk("m_idle", bus.busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported, fixed-latency memory between the pipeline's instruction-fetch port (IF) and data port (MEM-stage load/store). It serializes accesses, returns read data with a one-cycle ready pulse, and drives per-port stall signals so the pipeline freezes while its access is outstanding. It sits between the IF/MEM stages and the unified instruction/data memory.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata (≥1)
- STARVE_MAX, 4, consecutive data grants allowed while IF waits (≥1)
- clk  in  1  clock; all state on rising edge
- start  in  1  reset, asynchronous, active-low (start=0 resets, start=1 runs)
- if_req  in  1  IF read request; held until if_ready
- if_addr  in  ADDR_W  IF address
- if_ready  out  1  one-cycle completion pulse for IF
- if_rdata  out  DATA_W  fetched word; held until next IF completion
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle completion pulse for data
- d_rdata  out  DATA_W  load word; held until next data completion; unchanged by stores
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, valid with mem_en
- mem_addr, mem_wdata  out  ADDR_W/DATA_W  latched access address/data
- mem_rdata  in  DATA_W  memory read data
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_mem  out  1  d_req & ~d_ready (combinational)
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, GRANT_IF, GRANT_D.
- IDLE: on edge with a request sampled, latch port's addr/we/wdata, enter GRANT_*; else stay.
- Priority: data wins (older instruction), except when if_req high and streak == STARVE_MAX, then IF wins.
- streak: increments on each data grant while if_req high; clears on IF grant or when if_req low at a data grant; saturates at STARVE_MAX.
- GRANT_*: mem_en high in first cycle only; lat counter counts MEM_LAT cycles; at terminal count capture mem_rdata into the port's rdata register (loads/fetches only), pulse that port's ready, return to IDLE.
- Only one access outstanding; the other request waits with its stall high.
- Requester dropping req mid-access: access still completes and ready still pulses.
- req still high in cycle after ready = new request, arbitrated normally.
- IF writes impossible: mem_we=0 in GRANT_IF.

## Timing
- Reset (start=0, any time, including mid-access): state IDLE, counter and streak 0, mem_en, mem_we, if_ready, d_ready, busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; outstanding access abandoned, no ready pulse after release.
- Request sampled at edge k → mem_en high cycle k..k+1, ready high cycle k+MEM_LAT..k+MEM_LAT+1 (registered), i.e. MEM_LAT+1 cycles after sampling.
- mem_rdata sampled at the edge ending the MEM_LAT-th cycle after mem_en.
- Completion cycle returns to IDLE; next grant sampled at following edge: throughput one access per MEM_LAT+2 cycles.
- Simultaneous if_req and d_req in IDLE: priority rule above, loser untouched.
- Counter width $clog2(MEM_LAT+1); no wrap beyond MEM_LAT.

## Structure
- Shared package cpu_mem_pkg: arb_state_t enum {ARB_IDLE, ARB_GRANT_IF, ARB_GRANT_D}, default MEM_LAT/STARVE_MAX constants.
- One sub-module natural: mem_lat_counter (load, terminal-count pulse), reused by future multi-cycle units.

## Test plan
- Reset hold: start=0 with if_req=1 → all outputs 0, mem_en never asserts; release → IF grant, if_ready 3 cycles after first sampling edge.
- Single fetch: if_addr=0x10, mem_rdata=0x00500093 → mem_en one cycle, mem_addr=0x10, if_ready one cycle, if_rdata=0x00500093 held afterwards.
- Collision: if_req and d_req (load 0x40 → 0xDEAD) same cycle → data first, d_rdata=0xDEAD, then IF served; stall_if high throughout data access.
- Starvation: d_req held continuously, if_req high → exactly 4 data grants then 1 IF grant, pattern repeats.
- Store: d_we=1, d_addr=0x80, d_wdata=0x1234 → mem_we=1 with mem_en, d_ready pulses, d_rdata unchanged.
- Mid-access reset: start low during GRANT_D cycle 1 → no d_ready, busy=0 immediately, clean IDLE on release.
